// File: rtl/aes_fu_ctrl.sv
// aes_fu_ctrl: sequencing wrapper around an AES round-function core.
// Takes one instruction at a time from upstream with a valid/ready handshake.
// It rejects illegal op encodings locally. Legal ops go to the core, which
// presents core_valid and waits for core_ready. The result is then held on a
// valid/ready downstream port.
//
// Optional build macro AES_FU_FLUSH_EN adds a 'flush' input that aborts the
// in-flight op. When the core is still busy, the FSM parks in DRAIN until the
// core finishes, and that result is discarded.
module aes_fu_ctrl (
    input  logic        g_clk,
    input  logic        g_resetn,
`ifdef AES_FU_FLUSH_EN
    input  logic        flush,
`endif
    // upstream
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_dec,
    input  logic        in_op_sb,
    input  logic        in_op_sbsr,
    input  logic        in_op_mix,
    input  logic        in_hi,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_tag,
    // core side
    output logic        core_valid,
    output logic        core_dec,
    output logic        core_op_sb,
    output logic        core_op_sbsr,
    output logic        core_op_mix,
    output logic        core_hi,
    output logic [31:0] core_rs1,
    output logic [31:0] core_rs2,
    input  logic        core_ready,
    input  logic [31:0] core_rd,
    // downstream
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rd,
    output logic [4:0]  out_tag,
    output logic        out_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2
`ifdef AES_FU_FLUSH_EN
        ,S_DRAIN = 2'd3
`endif
    } state_t;

    state_t     state;
    logic [4:0] tag_q;
    logic       in_onehot;
    logic       in_legal;
    logic       accept;

    // Exactly one op bit may be set. Plain sub-bytes has no inverse form.
    assign in_onehot = ( in_op_sb & ~in_op_sbsr & ~in_op_mix) |
                       (~in_op_sb &  in_op_sbsr & ~in_op_mix) |
                       (~in_op_sb & ~in_op_sbsr &  in_op_mix);
    assign in_legal  = in_onehot & ~(in_op_sb & in_dec);

    // A flush wins over a same-cycle transfer, so ready is withheld and
    // upstream never sees a handshake that did not happen.
`ifdef AES_FU_FLUSH_EN
    assign in_ready = ((state == S_IDLE) | ((state == S_DONE) & out_ready)) & ~flush;
`else
    assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
`endif
    assign accept     = in_valid & in_ready;
    assign core_valid = (state == S_RUN);
    assign out_valid  = (state == S_DONE);

    // Control FSM plus operand/result registers, with a synchronous active-low reset.
    // NOTE: every flop here uses <= so all of them sample the pre-edge values;
    // with = the read of core_* later in the block would see the new operands.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state        <= S_IDLE;
            core_dec     <= 1'b0;
            core_op_sb   <= 1'b0;
            core_op_sbsr <= 1'b0;
            core_op_mix  <= 1'b0;
            core_hi      <= 1'b0;
            core_rs1     <= 32'd0;
            core_rs2     <= 32'd0;
            tag_q        <= 5'd0;
            out_rd       <= 32'd0;
            out_tag      <= 5'd0;
            out_err      <= 1'b0;
        end else begin
            // The operand fields change only when an op is taken. They stay stable
            // for the core through RUN and DRAIN.
            if (accept) begin
                core_dec     <= in_dec;
                core_op_sb   <= in_op_sb;
                core_op_sbsr <= in_op_sbsr;
                core_op_mix  <= in_op_mix;
                core_hi      <= in_hi;
                core_rs1     <= in_rs1;
                core_rs2     <= in_rs2;
                tag_q        <= in_tag;
            end

            // NOTE: this is a clocked block, so any state not listed keeps its value.
            // The default arm only recovers from an unreachable encoding.
            case (state)
                S_IDLE, S_DONE: begin
`ifdef AES_FU_FLUSH_EN
                    if (flush) begin
                        state <= S_IDLE;
                    end else
`endif
                    if (accept) begin
                        if (in_legal) begin
                            state <= S_RUN;
                        end else begin
                            // Illegal encodings complete at once and never reach the core.
                            state   <= S_DONE;
                            out_rd  <= 32'd0;
                            out_tag <= in_tag;
                            out_err <= 1'b1;
                        end
                    end else if (state == S_DONE && out_ready) begin
                        state <= S_IDLE;
                    end
                end

                S_RUN: begin
`ifdef AES_FU_FLUSH_EN
                    if (flush) begin
                        state <= core_ready ? S_IDLE : S_DRAIN;
                    end else
`endif
                    if (core_ready) begin
                        state   <= S_DONE;
                        out_rd  <= core_rd;
                        out_tag <= tag_q;
                        out_err <= 1'b0;
                    end
                end

`ifdef AES_FU_FLUSH_EN
                // The aborted op is still running in the core. Wait for it and drop its result.
                S_DRAIN: begin
                    if (core_ready) begin
                        state <= S_IDLE;
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_fu_ctrl.sv
// tb_aes_fu_ctrl: directed self-checking bench for aes_fu_ctrl.
// The core is a stand-in that raises core_ready in the 4th cycle after it
// starts. It returns rd = 0x63636363 ^ rs1 ^ rs2 ^ {dec, sb, mix, hi}.
// For op_sbsr on all-zero operands this gives 0x63636363.
module tb_aes_fu_ctrl;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
`ifdef AES_FU_FLUSH_EN
    logic        flush = 1'b0;
`endif
    logic        in_valid = 1'b0, in_ready;
    logic        in_dec = 1'b0, in_op_sb = 1'b0, in_op_sbsr = 1'b0, in_op_mix = 1'b0, in_hi = 1'b0;
    logic [31:0] in_rs1 = '0, in_rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        core_valid, core_dec, core_op_sb, core_op_sbsr, core_op_mix, core_hi;
    logic [31:0] core_rs1, core_rs2, core_rd;
    logic        core_ready;
    logic        out_valid, out_err;
    logic        out_ready = 1'b1;
    logic [31:0] out_rd;
    logic [4:0]  out_tag;

    int errors = 0;
    int checks = 0;

    aes_fu_ctrl dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
`ifdef AES_FU_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec), .in_op_sb(in_op_sb),
        .in_op_sbsr(in_op_sbsr), .in_op_mix(in_op_mix), .in_hi(in_hi),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .core_valid(core_valid), .core_dec(core_dec), .core_op_sb(core_op_sb),
        .core_op_sbsr(core_op_sbsr), .core_op_mix(core_op_mix), .core_hi(core_hi),
        .core_rs1(core_rs1), .core_rs2(core_rs2), .core_ready(core_ready), .core_rd(core_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_tag(out_tag), .out_err(out_err)
    );

    always #5 g_clk = ~g_clk;

    // Stand-in core: starts on core_valid and keeps running even if core_valid drops.
    logic       core_busy;
    logic [1:0] core_cnt;
    always @(posedge g_clk) begin
        if (!g_resetn) begin
            core_busy <= 1'b0;
            core_cnt  <= 2'd0;
        end else if (!core_busy) begin
            if (core_valid) begin
                core_busy <= 1'b1;
                core_cnt  <= 2'd1;
            end
        end else if (core_cnt == 2'd3) begin
            core_busy <= 1'b0;
        end else begin
            core_cnt <= core_cnt + 2'd1;
        end
    end
    assign core_ready = core_busy && (core_cnt == 2'd3);
    assign core_rd    = 32'h63636363 ^ core_rs1 ^ core_rs2 ^ {28'd0, core_dec, core_op_sb, core_op_mix, core_hi};

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc_end();
        @(posedge g_clk);
        #1;
    endtask

    task automatic set_op(input logic dec, input logic sb, input logic sbsr, input logic mix,
                          input logic hi, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t);
        in_valid = 1'b1; in_dec = dec; in_op_sb = sb; in_op_sbsr = sbsr; in_op_mix = mix;
        in_hi = hi; in_rs1 = a; in_rs2 = b; in_tag = t;
    endtask

    // Leaves the bench at a falling edge with out_valid high, or flags a timeout.
    task automatic wait_out(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge g_clk);
            if (out_valid === 1'b1) begin seen = 1'b1; break; end
            @(posedge g_clk); #1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL %s: out_valid timeout, got 0 want 1", name); end
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        repeat (2) cyc_end();
        @(negedge g_clk);
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL rst_core_valid: got %b want 0", core_valid); end
        checks++; if (out_rd !== 32'd0)    begin errors++; $display("FAIL rst_out_rd: got %h want 0", out_rd); end
        checks++; if (out_tag !== 5'd0)    begin errors++; $display("FAIL rst_out_tag: got %h want 0", out_tag); end
        checks++; if (out_err !== 1'b0)    begin errors++; $display("FAIL rst_out_err: got %b want 0", out_err); end
        checks++; if ({core_rs1, core_rs2} !== 64'd0) begin errors++; $display("FAIL rst_core_rs: got %h want 0", {core_rs1, core_rs2}); end
        checks++; if ({core_dec, core_op_sb, core_op_sbsr, core_op_mix, core_hi} !== 5'd0)
            begin errors++; $display("FAIL rst_core_ctl: got %b want 00000", {core_dec, core_op_sb, core_op_sbsr, core_op_mix, core_hi}); end
        g_resetn = 1'b1;
        cyc_end();
        @(negedge g_clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        cyc_end();
    endtask

    task automatic test_illegal();
        // {dec, sb, sbsr, mix}: sb+mix, sb with dec, no op
        logic [3:0] ops [3];
        ops[0] = 4'b0101; ops[1] = 4'b1100; ops[2] = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(ops[i][3], ops[i][2], ops[i][1], ops[i][0], 1'b0, 32'hDEADBEEF, 32'h1, 5'd7 + 5'(i));
            cyc_end();
            in_valid = 1'b0;
            @(negedge g_clk);
            checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL ill%0d_out_valid: got %b want 1", i, out_valid); end
            checks++; if (out_err !== 1'b1)    begin errors++; $display("FAIL ill%0d_out_err: got %b want 1", i, out_err); end
            checks++; if (out_rd !== 32'd0)    begin errors++; $display("FAIL ill%0d_out_rd: got %h want 0", i, out_rd); end
            checks++; if (out_tag !== 5'd7 + 5'(i)) begin errors++; $display("FAIL ill%0d_out_tag: got %0d want %0d", i, out_tag, 7 + i); end
            checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL ill%0d_core_valid: got %b want 0", i, core_valid); end
            cyc_end();
            @(negedge g_clk);
            checks++; if ({out_valid, core_valid, in_ready} !== 3'b001)
                begin errors++; $display("FAIL ill%0d_after: got %b want 001", i, {out_valid, core_valid, in_ready}); end
            cyc_end();
        end
    endtask

    task automatic test_legal();
        out_ready = 1'b1;
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd3);
        @(negedge g_clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL leg_in_ready: got %b want 1", in_ready); end
        cyc_end();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge g_clk);
            checks++; if ({core_valid, core_op_sbsr, out_valid, in_ready} !== 4'b1100)
                begin errors++; $display("FAIL leg_run_c%0d: got %b want 1100", k, {core_valid, core_op_sbsr, out_valid, in_ready}); end
            cyc_end();
        end
        @(negedge g_clk);
        checks++; if (out_valid !== 1'b1)     begin errors++; $display("FAIL leg_out_valid_c5: got %b want 1", out_valid); end
        checks++; if (out_rd !== 32'h63636363) begin errors++; $display("FAIL leg_out_rd: got %h want 63636363", out_rd); end
        checks++; if (out_tag !== 5'd3)       begin errors++; $display("FAIL leg_out_tag: got %0d want 3", out_tag); end
        checks++; if (out_err !== 1'b0)       begin errors++; $display("FAIL leg_out_err: got %b want 0", out_err); end
        checks++; if (core_valid !== 1'b0)    begin errors++; $display("FAIL leg_core_valid_c5: got %b want 0", core_valid); end
        cyc_end();
        @(negedge g_clk);
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL leg_idle: got %b want 01", {out_valid, in_ready}); end
        cyc_end();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0, 5'd9);
        cyc_end();
        in_valid = 1'b0;
        wait_out("bp_first");
        for (int k = 0; k < 10; k++) begin
            checks++; if ({out_valid, in_ready, out_tag, out_rd} !== {1'b1, 1'b0, 5'd9, 32'h63636366})
                begin errors++; $display("FAIL bp_hold%0d: got v=%b r=%b tag=%0d rd=%h want v=1 r=0 tag=9 rd=63636366",
                                         k, out_valid, in_ready, out_tag, out_rd); end
            cyc_end();
            @(negedge g_clk);
        end
        cyc_end();
        out_ready = 1'b1;
        set_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 5'd12);
        @(negedge g_clk);
        checks++; if ({out_valid, in_ready} !== 2'b11) begin errors++; $display("FAIL bp_release: got %b want 11", {out_valid, in_ready}); end
        cyc_end();
        in_valid = 1'b0;
        @(negedge g_clk);
        checks++; if ({core_valid, core_op_mix, core_hi, out_valid} !== 4'b1110)
            begin errors++; $display("FAIL bp_accept: got %b want 1110", {core_valid, core_op_mix, core_hi, out_valid}); end
        cyc_end();
        wait_out("bp_second");
        checks++; if ({out_tag, out_rd} !== {5'd12, 32'h63636360})
            begin errors++; $display("FAIL bp_second_res: got tag=%0d rd=%h want tag=12 rd=63636360", out_tag, out_rd); end
        cyc_end();
    endtask

    task automatic test_back_to_back();
        int         comp_t [4];
        logic [4:0] comp_tag [4];
        logic [31:0] comp_rd [4];
        logic       comp_err [4];
        int         ncomp = 0;
        int         nacc = 0;
        bit         acc;
        out_ready = 1'b1;
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 32'h22222222, 5'd20);
        for (int t = 0; t < 15; t++) begin
            @(negedge g_clk);
            if (out_valid === 1'b1 && ncomp < 4) begin
                comp_t[ncomp] = t; comp_tag[ncomp] = out_tag; comp_rd[ncomp] = out_rd; comp_err[ncomp] = out_err;
                ncomp++;
            end
            acc = (in_valid === 1'b1) && (in_ready === 1'b1);
            cyc_end();
            if (acc) begin
                nacc++;
                if (nacc == 1) set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h0000FFFF, 5'd21);
                else           in_valid = 1'b0;
            end
        end
        checks++;
        if (ncomp != 2) begin
            errors++; $display("FAIL b2b_count: got %0d completions want 2", ncomp);
        end else begin
            checks++; if (comp_t[0] != 5) begin errors++; $display("FAIL b2b_first_cycle: got %0d want 5", comp_t[0]); end
            checks++; if (comp_t[1] - comp_t[0] != 5) begin errors++; $display("FAIL b2b_spacing: got %0d want 5", comp_t[1] - comp_t[0]); end
            checks++; if ({comp_tag[0], comp_tag[1]} !== {5'd20, 5'd21})
                begin errors++; $display("FAIL b2b_tags: got %0d,%0d want 20,21", comp_tag[0], comp_tag[1]); end
            checks++; if ({comp_rd[0], comp_rd[1]} !== {32'h50505051, 32'hC6C63933})
                begin errors++; $display("FAIL b2b_rd: got %h,%h want 50505051,c6c63933", comp_rd[0], comp_rd[1]); end
            checks++; if ({comp_err[0], comp_err[1]} !== 2'b00)
                begin errors++; $display("FAIL b2b_err: got %b%b want 00", comp_err[0], comp_err[1]); end
        end
    endtask

`ifdef AES_FU_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b1;
        // C: accept
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd4);
        cyc_end();
        in_valid = 1'b0;
        cyc_end();
        // C+2: flush while running
        flush = 1'b1;
        @(negedge g_clk);
        checks++; if (core_valid !== 1'b1) begin errors++; $display("FAIL fl_run_c2: got %b want 1", core_valid); end
        cyc_end();
        flush = 1'b0;
        for (int k = 3; k <= 4; k++) begin
            @(negedge g_clk);
            checks++; if ({core_valid, in_ready, out_valid} !== 3'b000)
                begin errors++; $display("FAIL fl_drain_c%0d: got %b want 000", k, {core_valid, in_ready, out_valid}); end
            cyc_end();
        end
        @(negedge g_clk);
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL fl_c5: got %b want 10", {in_ready, out_valid}); end
        cyc_end();
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h01020304, 32'h0, 5'd5);
        cyc_end();
        in_valid = 1'b0;
        wait_out("fl_next");
        checks++; if ({out_tag, out_err, out_rd} !== {5'd5, 1'b0, 32'h62616067})
            begin errors++; $display("FAIL fl_next_res: got tag=%0d err=%b rd=%h want tag=5 err=0 rd=62616067", out_tag, out_err, out_rd); end
        cyc_end();
        // flush beats a same-cycle accept in IDLE
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd6);
        flush = 1'b1;
        @(negedge g_clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_prio_ready: got %b want 0", in_ready); end
        cyc_end();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge g_clk);
        checks++; if ({core_valid, out_valid} !== 2'b00) begin errors++; $display("FAIL fl_prio_noaccept: got %b want 00", {core_valid, out_valid}); end
        cyc_end();
        // flush in DONE drops the pending result
        out_ready = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd7);
        cyc_end();
        in_valid = 1'b0;
        wait_out("fl_done");
        cyc_end();
        flush = 1'b1;
        cyc_end();
        flush = 1'b0;
        @(negedge g_clk);
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL fl_done_drop: got %b want 01", {out_valid, in_ready}); end
        out_ready = 1'b1;
        cyc_end();
    endtask
`endif

    task automatic test_reset_mid();
        bit seen = 1'b0;
        out_ready = 1'b1;
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h55, 32'hAA, 5'd17);
        cyc_end();
        in_valid = 1'b0;
        cyc_end();
        cyc_end();
        // C+3: reset
        g_resetn = 1'b0;
        cyc_end();
        @(negedge g_clk);
        checks++; if ({in_ready, out_valid, core_valid, out_err} !== 4'b1000)
            begin errors++; $display("FAIL rm_ctl: got %b want 1000", {in_ready, out_valid, core_valid, out_err}); end
        checks++; if ({out_rd, out_tag} !== 37'd0) begin errors++; $display("FAIL rm_out: got rd=%h tag=%0d want 0", out_rd, out_tag); end
        checks++; if ({core_rs1, core_rs2, core_hi, core_op_sbsr} !== 66'd0)
            begin errors++; $display("FAIL rm_core_fields: got rs1=%h rs2=%h want 0", core_rs1, core_rs2); end
        g_resetn = 1'b1;
        cyc_end();
        for (int k = 0; k < 8; k++) begin
            @(negedge g_clk);
            if (out_valid !== 1'b0 || core_valid !== 1'b0) seen = 1'b1;
            cyc_end();
        end
        checks++; if (seen) begin errors++; $display("FAIL rm_stale: got activity after reset want none"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_illegal();
        test_legal();
        test_backpressure();
        test_back_to_back();
`ifdef AES_FU_FLUSH_EN
        test_flush();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
